mem_arbiter: RTL and testbench

Arbitrates the single shared memory port between the instruction fetch unit (IFU) and the load/store unit (LSU) of the RV32 core. It issues one transaction at a time to memory using valid/ready handshakes and routes the response back to the requester that was granted. By default the LSU has fixed priority. A timeout counter flags a memory port that stops responding.

---
 rtl/mem_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the IFU and LSU, one transaction in flight.
// Define ARB_RR_EN for round-robin arbitration; default build uses fixed LSU priority.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_resp_valid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                ls_req_valid,
  output logic                ls_req_ready,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic                ls_wen,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_wmask,
  output logic                ls_resp_valid,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                err
);

  // state | meaning
  // IDLE  | arbitrate, grant one requester and capture its request
  // REQ   | present captured request to memory until mem_req_ready
  // RESP  | wait for mem_resp_valid, then pulse the owner's response
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

  localparam int MASK_W = DATA_W / 8;
  localparam int TMR_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam bit TMR_EN = (TIMEOUT > 0);
  // Timer holds at most TIMEOUT-1: the expiring increment is what trips err.
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LS = 1'b1;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wen_q, wen_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [MASK_W-1:0]   wmask_q, wmask_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic                err_q, err_d;
  logic                if_resp_q, if_resp_d;
  logic                ls_resp_q, ls_resp_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   ls_rdata_q, ls_rdata_d;
`ifdef ARB_RR_EN
  logic                last_grant_q, last_grant_d;
`endif

  logic pick_ls, grant_ls, grant_if, timeout_hit;

`ifdef ARB_RR_EN
  assign pick_ls = ls_req_valid && (!if_req_valid || (last_grant_q == OWN_IF));
`else
  assign pick_ls = ls_req_valid;
`endif
  assign grant_ls    = (state_q == S_IDLE) && pick_ls;
  assign grant_if    = (state_q == S_IDLE) && if_req_valid && !pick_ls;
  assign timeout_hit = TMR_EN && (timer_q == TMR_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_IF;
      addr_q       <= '0;
      wen_q        <= 1'b0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      timer_q      <= '0;
      err_q        <= 1'b0;
      if_resp_q    <= 1'b0;
      ls_resp_q    <= 1'b0;
      if_rdata_q   <= '0;
      ls_rdata_q   <= '0;
`ifdef ARB_RR_EN
      last_grant_q <= OWN_IF;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      wen_q        <= wen_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
      timer_q      <= timer_d;
      err_q        <= err_d;
      if_resp_q    <= if_resp_d;
      ls_resp_q    <= ls_resp_d;
      if_rdata_q   <= if_rdata_d;
      ls_rdata_q   <= ls_rdata_d;
`ifdef ARB_RR_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    wen_d      = wen_q;
    wdata_d    = wdata_q;
    wmask_d    = wmask_q;
    err_d      = err_q;
    if_resp_d  = 1'b0;
    ls_resp_d  = 1'b0;
    if_rdata_d = if_rdata_q;
    ls_rdata_d = ls_rdata_q;
`ifdef ARB_RR_EN
    last_grant_d = last_grant_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (grant_ls) begin
          owner_d = OWN_LS;
          addr_d  = ls_addr;
          wen_d   = ls_wen;
          wdata_d = ls_wdata;
          wmask_d = ls_wmask;
          state_d = S_REQ;
`ifdef ARB_RR_EN
          last_grant_d = OWN_LS;
`endif
        end else if (grant_if) begin
          owner_d = OWN_IF;
          addr_d  = if_addr;
          wen_d   = 1'b0;
          wdata_d = '0;
          wmask_d = '0;
          state_d = S_REQ;
`ifdef ARB_RR_EN
          last_grant_d = OWN_IF;
`endif
        end
      end
      S_REQ: begin
        if (mem_req_ready) begin
          state_d = S_RESP;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_RESP: begin
        if (mem_resp_valid) begin
          state_d = S_IDLE;
          if (owner_q == OWN_LS) begin
            ls_resp_d  = 1'b1;
            ls_rdata_d = mem_rdata;
          end else begin
            if_resp_d  = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if ((state_d != state_q) || (state_q == S_IDLE)) timer_d = '0;
    else                                             timer_d = timer_q + 1'b1;
  end

  always_comb begin
    if_req_ready  = grant_if;
    ls_req_ready  = grant_ls;
    mem_req_valid = (state_q == S_REQ);
    mem_addr      = addr_q;
    mem_wen       = wen_q;
    mem_wdata     = wdata_q;
    mem_wmask     = wmask_q;
    if_resp_valid = if_resp_q;
    ls_resp_valid = ls_resp_q;
    if_rdata      = if_rdata_q;
    ls_rdata      = ls_rdata_q;
    err           = err_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a default-TIMEOUT instance plus a TIMEOUT=4 instance on shared inputs.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_valid, ls_req_valid, ls_wen;
  logic [31:0] if_addr, ls_addr, ls_wdata, mem_rdata;
  logic [3:0]  ls_wmask;
  logic        mem_req_ready, mem_resp_valid;

  logic        if_req_ready, if_resp_valid, ls_req_ready, ls_resp_valid;
  logic        mem_req_valid, mem_wen, err;
  logic [31:0] if_rdata, ls_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;

  logic        t4_if_req_ready, t4_if_resp_valid, t4_ls_req_ready, t4_ls_resp_valid;
  logic        t4_mem_req_valid, t4_mem_wen, t4_err;
  logic [31:0] t4_if_rdata, t4_ls_rdata, t4_mem_addr, t4_mem_wdata;
  logic [3:0]  t4_mem_wmask;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_resp_valid(if_resp_valid), .if_rdata(if_rdata),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_addr(ls_addr),
    .ls_wen(ls_wen), .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
    .ls_resp_valid(ls_resp_valid), .ls_rdata(ls_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .err(err)
  );

  mem_arbiter #(.TIMEOUT(4)) dut_t4 (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(t4_if_req_ready), .if_addr(if_addr),
    .if_resp_valid(t4_if_resp_valid), .if_rdata(t4_if_rdata),
    .ls_req_valid(ls_req_valid), .ls_req_ready(t4_ls_req_ready), .ls_addr(ls_addr),
    .ls_wen(ls_wen), .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
    .ls_resp_valid(t4_ls_resp_valid), .ls_rdata(t4_ls_rdata),
    .mem_req_valid(t4_mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(t4_mem_addr),
    .mem_wen(t4_mem_wen), .mem_wdata(t4_mem_wdata), .mem_wmask(t4_mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .err(t4_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    if_req_valid = 1'b0; ls_req_valid = 1'b0; ls_wen = 1'b0;
    if_addr = '0; ls_addr = '0; ls_wdata = '0; ls_wmask = '0;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_rdata = '0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  logic [6:0]  exp_ls_rdy, exp_if_rdy;
  logic [31:0] exp_addr4;

  initial begin
    do_reset();
    #1;
    check("rst_if_req_ready", if_req_ready, 0);
    check("rst_ls_req_ready", ls_req_ready, 0);
    check("rst_mem_req_valid", mem_req_valid, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_mem_wmask", mem_wmask, 0);
    check("rst_resp_valids", {if_resp_valid, ls_resp_valid}, 0);
    check("rst_rdata", {if_rdata, ls_rdata}, 0);
    check("rst_err", err, 0);
    cyc();

    // IFU fetch, memory ready and responding immediately
    if_req_valid = 1'b1; if_addr = 32'h8000_0000; mem_rdata = 32'h0000_0413;
    #1;
    check("f_c0_if_ready", if_req_ready, 1);
    check("f_c0_ls_ready", ls_req_ready, 0);
    cyc();
    if_req_valid = 1'b0; #1;
    check("f_c1_mem_valid", mem_req_valid, 1);
    check("f_c1_mem_addr", mem_addr, 32'h8000_0000);
    check("f_c1_mem_wen", mem_wen, 0);
    check("f_c1_mem_wmask", mem_wmask, 0);
    cyc(); #1;
    check("f_c2_mem_valid", mem_req_valid, 0);
    check("f_c2_if_resp", if_resp_valid, 0);
    cyc(); #1;
    check("f_c3_if_resp", if_resp_valid, 1);
    check("f_c3_if_rdata", if_rdata, 32'h0000_0413);
    check("f_c3_ls_resp", ls_resp_valid, 0);
    cyc(); #1;
    check("f_c4_if_resp_pulse", if_resp_valid, 0);
    check("f_c4_if_rdata_hold", if_rdata, 32'h0000_0413);
    cyc();

    // LSU store
    ls_req_valid = 1'b1; ls_addr = 32'h8000_1000; ls_wen = 1'b1;
    ls_wdata = 32'hDEAD_BEEF; ls_wmask = 4'hF; mem_rdata = 32'h1234_5678;
    #1;
    check("s_c0_ls_ready", ls_req_ready, 1);
    check("s_c0_if_ready", if_req_ready, 0);
    cyc();
    ls_req_valid = 1'b0; #1;
    check("s_c1_mem_valid", mem_req_valid, 1);
    check("s_c1_mem_addr", mem_addr, 32'h8000_1000);
    check("s_c1_mem_wen", mem_wen, 1);
    check("s_c1_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    check("s_c1_mem_wmask", mem_wmask, 4'hF);
    cyc(); cyc(); #1;
    check("s_c3_ls_resp", ls_resp_valid, 1);
    check("s_c3_ls_rdata", ls_rdata, 32'h1234_5678);
    check("s_c3_if_resp", if_resp_valid, 0);
    cyc(); #1;
    check("s_c4_ls_resp_pulse", ls_resp_valid, 0);
    check("s_c4_if_rdata_kept", if_rdata, 32'h0000_0413);
    cyc();

    // Both requesters valid every cycle; grants at cycles 0, 3, 6
    do_reset();
    ls_wen = 1'b0;
`ifdef ARB_RR_EN
    exp_ls_rdy = 7'b100_0001;
    exp_if_rdy = 7'b000_1000;
    exp_addr4  = 32'h8000_0010;
`else
    exp_ls_rdy = 7'b100_1001;
    exp_if_rdy = 7'b000_0000;
    exp_addr4  = 32'h8000_0020;
`endif
    for (int c = 0; c < 7; c++) begin
      if_req_valid = 1'b1; ls_req_valid = 1'b1;
      if_addr = 32'h8000_0010; ls_addr = 32'h8000_0020;
      #1;
      check($sformatf("arb_c%0d_ls_ready", c), ls_req_ready, exp_ls_rdy[c]);
      check($sformatf("arb_c%0d_if_ready", c), if_req_ready, exp_if_rdy[c]);
      if (c == 4) check("arb_c4_mem_addr", mem_addr, exp_addr4);
      cyc();
    end
    if_req_valid = 1'b0; ls_req_valid = 1'b0;
    cyc(); cyc(); cyc();

    // Memory stalls the request for 5 cycles; captured fields must hold
    ls_req_valid = 1'b1; ls_addr = 32'h8000_2000; ls_wen = 1'b1;
    ls_wdata = 32'hCAFE_F00D; ls_wmask = 4'h3; mem_req_ready = 1'b0;
    #1;
    check("st_c0_ls_ready", ls_req_ready, 1);
    cyc();
    for (int c = 1; c <= 5; c++) begin
      ls_req_valid = 1'b0;
      ls_addr = $urandom; ls_wdata = $urandom; ls_wmask = 4'($urandom);
      #1;
      check($sformatf("st_c%0d_mem_valid", c), mem_req_valid, 1);
      check($sformatf("st_c%0d_mem_addr", c), mem_addr, 32'h8000_2000);
      check($sformatf("st_c%0d_mem_wdata", c), mem_wdata, 32'hCAFE_F00D);
      check($sformatf("st_c%0d_ls_resp", c), ls_resp_valid, 0);
      cyc();
    end
    mem_req_ready = 1'b1; #1;
    check("st_c6_mem_valid", mem_req_valid, 1);
    check("st_c6_mem_wmask", mem_wmask, 4'h3);
    cyc();
    mem_rdata = 32'h0BAD_F00D; #1;
    check("st_c7_mem_valid", mem_req_valid, 0);
    cyc(); #1;
    check("st_c8_ls_resp", ls_resp_valid, 1);
    check("st_c8_ls_rdata", ls_rdata, 32'h0BAD_F00D);
    check("st_c8_err", err, 0);
    cyc();

    // Timeout on the TIMEOUT=4 instance; memory never accepts
    do_reset();
    if_req_valid = 1'b1; if_addr = 32'h8000_0100; mem_req_ready = 1'b0; mem_rdata = 32'h1111_0000;
    #1;
    check("to_c0_if_ready", t4_if_req_ready, 1);
    cyc();
    if_req_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      #1;
      check($sformatf("to_c%0d_err", c), t4_err, 0);
      check($sformatf("to_c%0d_mem_valid", c), t4_mem_req_valid, 1);
      cyc();
    end
    mem_req_ready = 1'b1; #1;
    check("to_c5_err", t4_err, 1);
    check("to_c5_mem_valid", t4_mem_req_valid, 0);
    check("to_c5_if_resp", t4_if_resp_valid, 0);
    check("to_c5_main_err", err, 0);
    check("to_c5_main_mem_valid", mem_req_valid, 1);
    cyc(); #1;
    check("to_c6_if_resp", t4_if_resp_valid, 0);
    check("to_c6_ls_resp", t4_ls_resp_valid, 0);
    cyc();
    if_req_valid = 1'b1; if_addr = 32'h8000_0200; mem_rdata = 32'hABCD_0001;
    #1;
    check("to_c7_main_if_resp", if_resp_valid, 1);
    check("to_c7_main_if_rdata", if_rdata, 32'h1111_0000);
    check("to_c7_t4_if_resp", t4_if_resp_valid, 0);
    check("to_c7_t4_if_ready", t4_if_req_ready, 1);
    check("to_c7_main_if_ready", if_req_ready, 1);
    cyc();
    if_req_valid = 1'b0; #1;
    check("to_c8_t4_mem_addr", t4_mem_addr, 32'h8000_0200);
    cyc(); cyc(); #1;
    check("to_c10_t4_if_resp", t4_if_resp_valid, 1);
    check("to_c10_t4_if_rdata", t4_if_rdata, 32'hABCD_0001);
    check("to_c10_t4_err_sticky", t4_err, 1);
    cyc();

    // Reset while in RESP, then a stale memory response
    mem_resp_valid = 1'b0;
    ls_req_valid = 1'b1; ls_addr = 32'h8000_3000; ls_wen = 1'b0; mem_rdata = 32'h5555_AAAA;
    #1;
    check("rr_c0_ls_ready", ls_req_ready, 1);
    cyc();
    ls_req_valid = 1'b0;
    cyc(); #1;
    check("rr_c2_mem_addr", mem_addr, 32'h8000_3000);
    rst = 1'b1;
    cyc();
    rst = 1'b0; mem_resp_valid = 1'b1; #1;
    check("rr_c3_mem_valid", mem_req_valid, 0);
    check("rr_c3_mem_addr", mem_addr, 0);
    check("rr_c3_if_rdata", if_rdata, 0);
    check("rr_c3_resp", {if_resp_valid, ls_resp_valid}, 0);
    check("rr_c3_t4_err", t4_err, 0);
    cyc();
    mem_resp_valid = 1'b0; #1;
    check("rr_c4_resp", {if_resp_valid, ls_resp_valid}, 0);
    check("rr_c4_ls_rdata", ls_rdata, 0);
    check("rr_c4_mem_valid", mem_req_valid, 0);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
